// File: rtl/xbox_apb_host_regs.sv
// APB slave owning the 32x32 host register file plus per-register accelerator status capture.
// Latency: setup + (1 + WAIT_STATES) access cycles; write pulses appear the cycle after completion.
// Backpressure: pready held low for WAIT_STATES access cycles; optional pslverr via XBOX_APB_PSLVERR_EN.
module xbox_apb_host_regs #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_W-1:0]       paddr,
    input  logic [31:0]             pwdata,
    input  logic [3:0]              pstrb,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [31:0][31:0]       host_regs,
    output logic [31:0]             host_regs_valid_pulse,
    input  logic [31:0][31:0]       host_regs_data_out,
    input  logic [31:0]             host_regs_valid_out
);

    logic              access;
    logic              complete;
    logic              legal;
    logic              wr_done;
    logic [3:0]        wcnt;
    logic [4:0]        idx;
    logic [31:0][31:0] shadow;
    logic [31:0]       cap;

    assign access   = psel & penable;
    assign pready   = access & (wcnt == 4'(WAIT_STATES));
    assign complete = pready;
    assign idx      = paddr[6:2];

`ifdef XBOX_APB_PSLVERR_EN
    assign legal   = ((paddr >> 7) == '0) && (paddr[1:0] == 2'b00);
    assign pslverr = complete & ~legal;
`else
    // Upper and low address bits alias in this build.
    logic unused_addr;
    assign unused_addr = ^paddr;
    assign legal   = 1'b1;
    assign pslverr = 1'b0;
`endif

    assign wr_done = complete & pwrite & legal;

    // Wait counter restarts on completion or whenever the master drops psel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 4'd0;
        end else if (!psel || complete) begin
            wcnt <= 4'd0;
        end else if (access) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_regs             <= '0;
            host_regs_valid_pulse <= '0;
        end else begin
            host_regs_valid_pulse <= wr_done ? (32'd1 << idx) : 32'd0;
            if (wr_done) begin
                for (int b = 0; b < 4; b++) begin
                    if (pstrb[b]) begin
                        host_regs[idx][8*b +: 8] <= pwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Capture set takes priority over the clear from a coincident software write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            cap    <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (host_regs_valid_out[i]) begin
                    shadow[i] <= host_regs_data_out[i];
                    cap[i]    <= 1'b1;
                end else if (wr_done && (idx == 5'(i))) begin
                    cap[i]    <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        prdata = 32'd0;
        if (complete && !pwrite && legal) begin
            prdata = cap[idx] ? shadow[idx] : host_regs[idx];
        end
    end

endmodule
